// File: rtl/ycc_pkg.sv
// Shared YCrCb->RGB definitions: component tags, Q7 coefficients, result packing.
package ycc_pkg;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned ACC_W  = 18;
    localparam int unsigned FRAC_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        Y    = 2'b01,
        CR   = 2'b10,
        CB   = 2'b11
    } mode_e;

    localparam logic signed [ACC_W-1:0] COEF_R_CR = 18'sd179;
    localparam logic signed [ACC_W-1:0] COEF_G_CB = 18'sd44;
    localparam logic signed [ACC_W-1:0] COEF_G_CR = 18'sd91;
    localparam logic signed [ACC_W-1:0] COEF_B_CB = 18'sd227;
    localparam logic signed [ACC_W-1:0] Q7_RND    = 18'sd64;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

    // Reduce a wide signed result to 8 bits, clamping when sat is set, wrapping otherwise.
    function automatic logic [PIX_W-1:0] fit_u8(input logic signed [ACC_W-1:0] v,
                                                 input logic sat);
        logic [PIX_W-1:0] res;
        res = v[PIX_W-1:0];
        if (sat) begin
            if (v < ACC_W'(0)) begin
                res = '0;
            end else if (v > ACC_W'(255)) begin
                res = '1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ycrcb_to_rgb_if.sv
// Component-beat input and RGB-beat output bus of ycrcb_to_rgb.
interface ycrcb_to_rgb_if #(
    parameter int unsigned DATA_NUM = 4
);
    logic                                       in_valid;
    logic                                       in_ready;
    logic [1:0]                                 in_mode;
    logic [DATA_NUM-1:0][ycc_pkg::PIX_W-1:0]    in_data;
    logic                                       out_valid;
    logic                                       out_ready;
    logic [DATA_NUM-1:0][ycc_pkg::PIX_W-1:0]    out_R;
    logic [DATA_NUM-1:0][ycc_pkg::PIX_W-1:0]    out_G;
    logic [DATA_NUM-1:0][ycc_pkg::PIX_W-1:0]    out_B;
    logic                                       err;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_R, out_G, out_B, err
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_R, out_G, out_B, err
    );
endinterface

// File: rtl/ycc2rgb_pixel.sv
// One pixel of Q7 YCrCb->RGB conversion, purely combinational.
// YCRCB_TO_RGB_SAT_EN defined: clamp results to 0..255; undefined: keep low 8 bits.
module ycc2rgb_pixel
    import ycc_pkg::*;
(
    input  logic [PIX_W-1:0] i_y,
    input  logic [PIX_W-1:0] i_cr,
    input  logic [PIX_W-1:0] i_cb,
    output rgb_t             o_rgb_c
);

`ifdef YCRCB_TO_RGB_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic signed [ACC_W-1:0] w_y;
    logic signed [ACC_W-1:0] w_cr;
    logic signed [ACC_W-1:0] w_cb;
    logic signed [ACC_W-1:0] w_yp;
    logic signed [ACC_W-1:0] w_r;
    logic signed [ACC_W-1:0] w_g;
    logic signed [ACC_W-1:0] w_b;

    assign w_y  = ACC_W'($signed(i_y));
    assign w_cr = ACC_W'($signed(i_cr));
    assign w_cb = ACC_W'($signed(i_cb));
    assign w_yp = w_y + ACC_W'(128);

    // Rounded Q7 chroma terms; >>> on signed operands floors toward -inf.
    assign w_r = w_yp + ((COEF_R_CR * w_cr + Q7_RND) >>> FRAC_W);
    assign w_g = w_yp - ((COEF_G_CB * w_cb + COEF_G_CR * w_cr + Q7_RND) >>> FRAC_W);
    assign w_b = w_yp + ((COEF_B_CB * w_cb + Q7_RND) >>> FRAC_W);

    assign o_rgb_c.r = fit_u8(w_r, SAT);
    assign o_rgb_c.g = fit_u8(w_g, SAT);
    assign o_rgb_c.b = fit_u8(w_b, SAT);

endmodule

// File: rtl/ycrcb_to_rgb.sv
// Collects Y, Cr, Cb beats in order, converts DATA_NUM pixels and holds the RGB beat.
// Output range handling follows YCRCB_TO_RGB_SAT_EN (see ycc2rgb_pixel).
module ycrcb_to_rgb
    import ycc_pkg::*;
#(
    parameter int unsigned DATA_NUM = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    ycrcb_to_rgb_if.slave  bus
);

    typedef enum logic [2:0] {
        WAIT_Y  = 3'd0,
        WAIT_CR = 3'd1,
        WAIT_CB = 3'd2,
        CALC    = 3'd3,
        HOLD    = 3'd4
    } state_e;

    typedef logic [DATA_NUM-1:0][PIX_W-1:0] beat_t;

    state_e r_state;
    state_e w_state_nxt;

    beat_t  r_y;
    beat_t  r_cr;
    beat_t  r_cb;
    beat_t  r_out_r;
    beat_t  r_out_g;
    beat_t  r_out_b;
    logic   r_in_ready;
    logic   r_out_valid;
    logic   r_err;

    mode_e  w_mode;
    logic   w_in_hs;
    logic   w_out_hs;
    logic   w_store_y;
    logic   w_store_cr;
    logic   w_store_cb;
    logic   w_bad_tag;
    logic   w_in_ready_nxt;
    logic   w_out_valid_nxt;
    logic   w_load_out;
    rgb_t   w_pix [DATA_NUM];

    assign w_mode   = mode_e'(bus.in_mode);
    assign w_in_hs  = bus.in_valid & r_in_ready;
    assign w_out_hs = r_out_valid & bus.out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_Y;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus tag decode; a wrong tag restarts collection (Y restarts at WAIT_CR)
    always_comb begin
        w_state_nxt = r_state;
        w_store_y   = 1'b0;
        w_store_cr  = 1'b0;
        w_store_cb  = 1'b0;
        w_bad_tag   = 1'b0;
        unique case (r_state)
            WAIT_Y: begin
                if (w_in_hs) begin
                    unique case (w_mode)
                        Y: begin
                            w_store_y   = 1'b1;
                            w_state_nxt = WAIT_CR;
                        end
                        CR, CB: w_bad_tag = 1'b1;
                        IDLE: ;
                        default: ;
                    endcase
                end
            end
            WAIT_CR: begin
                if (w_in_hs) begin
                    unique case (w_mode)
                        Y: begin
                            w_bad_tag   = 1'b1;
                            w_store_y   = 1'b1;
                            w_state_nxt = WAIT_CR;
                        end
                        CR: begin
                            w_store_cr  = 1'b1;
                            w_state_nxt = WAIT_CB;
                        end
                        CB: begin
                            w_bad_tag   = 1'b1;
                            w_state_nxt = WAIT_Y;
                        end
                        IDLE: ;
                        default: ;
                    endcase
                end
            end
            WAIT_CB: begin
                if (w_in_hs) begin
                    unique case (w_mode)
                        Y: begin
                            w_bad_tag   = 1'b1;
                            w_store_y   = 1'b1;
                            w_state_nxt = WAIT_CR;
                        end
                        CR: begin
                            w_bad_tag   = 1'b1;
                            w_state_nxt = WAIT_Y;
                        end
                        CB: begin
                            w_store_cb  = 1'b1;
                            w_state_nxt = CALC;
                        end
                        IDLE: ;
                        default: ;
                    endcase
                end
            end
            CALC: w_state_nxt = HOLD;
            HOLD: begin
                if (w_out_hs) begin
                    w_state_nxt = WAIT_Y;
                end
            end
            default: w_state_nxt = WAIT_Y;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_load_out      = 1'b0;
        if (w_state_nxt == WAIT_Y || w_state_nxt == WAIT_CR || w_state_nxt == WAIT_CB) begin
            w_in_ready_nxt = 1'b1;
        end
        if (r_state == HOLD && !w_out_hs) begin
            w_out_valid_nxt = 1'b1;
        end
        if (r_state == CALC) begin
            w_load_out = 1'b1;
        end
    end

    for (genvar gi = 0; gi < DATA_NUM; gi++) begin : g_pix
        ycc2rgb_pixel u_pix (
            .i_y     (r_y[gi]),
            .i_cr    (r_cr[gi]),
            .i_cb    (r_cb[gi]),
            .o_rgb_c (w_pix[gi])
        );
    end

    // Component buffers, result registers and handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y         <= '0;
            r_cr        <= '0;
            r_cb        <= '0;
            r_out_r     <= '0;
            r_out_g     <= '0;
            r_out_b     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_err       <= w_bad_tag;
            if (w_bad_tag) begin
                r_cr <= '0;
                r_cb <= '0;
                if (!w_store_y) begin
                    r_y <= '0;
                end
            end
            if (w_store_y) begin
                r_y <= bus.in_data;
            end
            if (w_store_cr) begin
                r_cr <= bus.in_data;
            end
            if (w_store_cb) begin
                r_cb <= bus.in_data;
            end
            if (w_load_out) begin
                for (int i = 0; i < int'(DATA_NUM); i++) begin
                    r_out_r[i] <= w_pix[i].r;
                    r_out_g[i] <= w_pix[i].g;
                    r_out_b[i] <= w_pix[i].b;
                end
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_R     = r_out_r;
    assign bus.out_G     = r_out_g;
    assign bus.out_B     = r_out_b;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_ycrcb_to_rgb.sv
// Scoreboard bench for ycrcb_to_rgb: directed corner cases plus randomized beat streams.
module tb_ycrcb_to_rgb;
    import ycc_pkg::*;

    localparam int unsigned DN      = 4;
    localparam int          TIMEOUT = 200;

`ifdef YCRCB_TO_RGB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef logic [DN-1:0][7:0] beat_t;
    typedef struct packed { beat_t r; beat_t g; beat_t b; } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ycrcb_to_rgb_if #(.DATA_NUM(DN)) bus ();

    ycrcb_to_rgb #(.DATA_NUM(DN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   err_seen = 0;
    int   err_exp  = 0;
    int   xfers    = 0;
    exp_t exp_q[$];
    int   phase    = 0;
    int   my  [DN];
    int   mcr [DN];
    bit   rnd_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int fit(input int v);
        if (SAT) return (v < 0) ? 0 : ((v > 255) ? 255 : v);
        return v & 255;
    endfunction

    // Reference conversion straight from the Q7 formulas with integer arithmetic
    function automatic exp_t ref_beat(input int ys[DN], input int crs[DN], input int cbs[DN]);
        exp_t e;
        int yp, r, g, b;
        for (int i = 0; i < int'(DN); i++) begin
            yp = ys[i] + 128;
            r  = yp + ((179 * crs[i] + 64) >>> 7);
            g  = yp - ((44 * cbs[i] + 91 * crs[i] + 64) >>> 7);
            b  = yp + ((227 * cbs[i] + 64) >>> 7);
            e.r[i] = 8'(fit(r));
            e.g[i] = 8'(fit(g));
            e.b[i] = 8'(fit(b));
        end
        return e;
    endfunction

    // phase = how many in-order components are held: 0 none, 1 Y, 2 Y+Cr
    task automatic model_beat(input logic [1:0] mode, input beat_t d);
        int cbs [DN];
        case (mode)
            2'b01: begin
                if (phase != 0) err_exp++;
                for (int i = 0; i < int'(DN); i++) my[i] = $signed(d[i]);
                phase = 1;
            end
            2'b10: begin
                if (phase == 1) begin
                    for (int i = 0; i < int'(DN); i++) mcr[i] = $signed(d[i]);
                    phase = 2;
                end else begin
                    err_exp++;
                    phase = 0;
                end
            end
            2'b11: begin
                if (phase == 2) begin
                    for (int i = 0; i < int'(DN); i++) cbs[i] = $signed(d[i]);
                    exp_q.push_back(ref_beat(my, mcr, cbs));
                end else begin
                    err_exp++;
                end
                phase = 0;
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] mode, input beat_t d);
        int n;
        bit rdy;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_mode  = mode;
        bus.in_data  = d;
        forever begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            if (rdy) break;
            #1;
            if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
            n++;
            if (n > TIMEOUT) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: in_ready got 0 expected 1 within %0d cycles", TIMEOUT);
                bus.in_valid = 1'b0;
                return;
            end
        end
        #1;
        bus.in_valid = 1'b0;
        bus.in_mode  = 2'b00;
        if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        model_beat(mode, d);
    endtask

    task automatic send3(input beat_t y, input beat_t cr, input beat_t cb);
        send(2'b01, y);
        send(2'b10, cr);
        send(2'b11, cb);
    endtask

    task automatic wait_valid(input string name);
        for (int n = 0; n < TIMEOUT && !bus.out_valid; n++) tick();
        chk(name, bus.out_valid, 1);
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < TIMEOUT && (exp_q.size() != 0 || bus.out_valid); n++) tick();
        chk(name, exp_q.size(), 0);
    endtask

    function automatic beat_t rnd_beat();
        return beat_t'($urandom());
    endfunction

    // Monitor: pops the scoreboard on every output transfer, counts err pulses
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.err) err_seen++;
            if (rst_n && bus.out_valid && bus.out_ready) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got R=%0h expected no transfer", bus.out_R);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_R", bus.out_R, e.r);
                    chk("out_G", bus.out_G, e.g);
                    chk("out_B", bus.out_B, e.b);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation got no end expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t y, cr, cb, d;
        logic [1:0] mode;
        int r, xf, es;

        bus.in_valid  = 1'b0;
        bus.in_mode   = 2'b00;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_out_R", bus.out_R, 0);
        chk("rst_out_G", bus.out_G, 0);
        chk("rst_out_B", bus.out_B, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_pre_edge", bus.in_ready, 0);
        tick();
        chk("in_ready_post_edge", bus.in_ready, 1);

        // Black pixels and output latency
        bus.out_ready = 1'b1;
        send3({DN{8'h80}}, '0, '0);
        chk("lat_edge0", bus.out_valid, 0);
        chk("lat_in_ready_calc", bus.in_ready, 0);
        tick();
        chk("lat_edge1", bus.out_valid, 0);
        tick();
        chk("lat_edge2", bus.out_valid, 1);
        chk("black_R", bus.out_R, 0);
        tick();
        chk("black_done", bus.out_valid, 0);
        chk("black_no_err", err_seen, 0);

        // Red-heavy chroma: saturates or wraps in R
        send3('0, {DN{8'h7F}}, '0);
        wait_valid("cr127_valid");
        chk("cr127_R", bus.out_R, SAT ? 32'hFFFFFFFF : 32'h32323232);
        chk("cr127_G", bus.out_G, 32'h26262626);
        chk("cr127_B", bus.out_B, 32'h80808080);
        drain("cr127_drain");

        // Negative Cb: negative B, positive G
        send3({DN{8'h80}}, '0, {DN{8'h80}});
        wait_valid("cbneg_valid");
        chk("cbneg_R", bus.out_R, 0);
        chk("cbneg_G", bus.out_G, 32'h2C2C2C2C);
        chk("cbneg_B", bus.out_B, SAT ? 32'h0 : 32'h1D1D1D1D);
        drain("cbneg_drain");

        // Out-of-order tags
        xf = xfers;
        es = err_seen;
        send(2'b01, rnd_beat());
        send(2'b11, rnd_beat());
        chk("ooo_err_pulse", bus.err, 1);
        send(2'b10, rnd_beat());
        send(2'b11, rnd_beat());
        @(negedge clk);
        #1;
        chk("ooo_err_count", err_seen - es, err_exp - es);
        tick();
        tick();
        chk("ooo_no_valid", bus.out_valid, 0);
        chk("ooo_no_xfer", xfers, xf);
        send(2'b00, rnd_beat());
        send3(rnd_beat(), rnd_beat(), rnd_beat());
        drain("ooo_recover");
        chk("ooo_one_xfer", xfers, xf + 1);

        // Backpressure in HOLD
        bus.out_ready = 1'b0;
        send3(rnd_beat(), rnd_beat(), rnd_beat());
        wait_valid("bp_valid");
        for (int i = 0; i < 5; i++) begin
            chk("bp_R", bus.out_R, exp_q[0].r);
            chk("bp_G", bus.out_G, exp_q[0].g);
            chk("bp_B", bus.out_B, exp_q[0].b);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_valid_hold", bus.out_valid, 1);
            tick();
        end
        xf = xfers;
        bus.out_ready = 1'b1;
        drain("bp_drain");
        chk("bp_one_xfer", xfers, xf + 1);

        // Reset pulse while holding a result
        bus.out_ready = 1'b0;
        send3(rnd_beat(), rnd_beat(), rnd_beat());
        wait_valid("rst_hold_valid");
        xf = xfers;
        rst_n = 1'b0;
        #1;
        chk("rst_hold_valid_drop", bus.out_valid, 0);
        chk("rst_hold_in_ready", bus.in_ready, 0);
        exp_q.delete();
        phase = 0;
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (6) tick();
        chk("rst_hold_no_valid", bus.out_valid, 0);
        chk("rst_hold_no_xfer", xfers, xf);
        chk("rst_hold_in_ready_back", bus.in_ready, 1);

        // Randomized stream with random tags and random backpressure
        rnd_ready = 1'b1;
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       mode = (phase == 0) ? 2'b01 : ((phase == 1) ? 2'b10 : 2'b11);
            else if (r == 7) mode = 2'b00;
            else             mode = 2'($urandom_range(1, 3));
            d = rnd_beat();
            send(mode, d);
        end
        rnd_ready = 1'b0;
        bus.out_ready = 1'b1;
        drain("rand_drain");
        @(negedge clk);
        #1;
        chk("rand_err_count", err_seen, err_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
